bp_update_ctrl: RTL

Controller that sequences all write traffic into the tournament branch predictor's single-ported tables (BTB, local BHT, global PHT, selector).
- Sweeps every table index after reset or flush.
- Buffers branch resolutions from Execute in a small FIFO.
- Arbitrates the table port between Fetch lookups and queued updates, with a starvation guard.
- Sits between the Execute/Writeback resolution path and the predictor's `update_i`, and gates Fetch use of predictions.

---
 rtl/riscv_types_pkg.sv | 21 ++
 rtl/bp_update_fifo.sv | 65 ++++++
 rtl/bp_update_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_types_pkg.sv
// Shared branch-predictor types and default sizing for the predictor update path.
package riscv_types_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
    logic        is_cond;
  } branch_update_t;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bp_ctrl_state_e;

  localparam int BP_UPD_FIFO_DEPTH = 4;
  localparam int BP_INIT_ENTRIES   = 4096;
  localparam int BP_STARVE_LIMIT   = 3;

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO of branch resolutions; clear wins over push and pop.
module bp_update_fifo
  import riscv_types_pkg::*;
#(
  parameter int DEPTH = BP_UPD_FIFO_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  branch_update_t         data_i,
  input  logic                   pop_i,
  output branch_update_t         head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  branch_update_t   mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_r == CNT_W'(DEPTH));
  assign empty_o   = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push_i && !full_o && !clear_i;
  assign do_pop_s  = pop_i && !empty_o && !clear_i;
  assign head_o    = empty_o ? {$bits(branch_update_t){1'b0}} : mem_r[rd_ptr_r];
  assign count_o   = count_r;

  // Pointers, occupancy and storage; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(branch_update_t){1'b0}};
      end
    end else if (clear_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Sequences predictor table writes: post-reset/flush index sweep, then arbitration
// of the single table port between Fetch lookups and queued branch updates.
module bp_update_ctrl
  import riscv_types_pkg::*;
#(
  parameter int FIFO_DEPTH   = BP_UPD_FIFO_DEPTH,
  parameter int INIT_ENTRIES = BP_INIT_ENTRIES,
  parameter int STARVE_LIMIT = BP_STARVE_LIMIT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          upd_valid_i,
  input  branch_update_t                upd_i,
  output logic                          upd_ready_o,
  input  logic                          lookup_req_i,
  output logic                          lookup_stall_o,
  input  logic                          flush_req_i,
  output logic                          pred_upd_valid_o,
  output branch_update_t                pred_upd_o,
  output logic                          init_valid_o,
  output logic [$clog2(INIT_ENTRIES)-1:0] init_index_o,
  output logic                          pred_disable_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int                IDX_W    = $clog2(INIT_ENTRIES);
  localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(INIT_ENTRIES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  bp_ctrl_state_e    state_r;
  bp_ctrl_state_e    state_next_s;
  logic [IDX_W-1:0]  index_r;
  logic [IDX_W-1:0]  index_next_s;
  logic [WAIT_W-1:0] wait_r;
  logic [WAIT_W-1:0] wait_next_s;
  logic              init_active_r;
  logic              in_run_s;
  logic              ready_s;
  logic              grant_s;
  logic              push_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  branch_update_t    head_s;

  bp_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_req_i),
    .push_i  (push_s),
    .data_i  (upd_i),
    .pop_i   (grant_s),
    .head_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (count_o)
  );

  // Next state and sweep index; a flush in either state restarts the sweep at 0.
  always_comb begin
    state_next_s = state_r;
    index_next_s = index_r;
    case (state_r)
      S_INIT: begin
        if (flush_req_i) begin
          state_next_s = S_INIT;
          index_next_s = {IDX_W{1'b0}};
        end else if (index_r == LAST_IDX) begin
          state_next_s = S_RUN;
          index_next_s = {IDX_W{1'b0}};
        end else begin
          state_next_s = S_INIT;
          index_next_s = index_r + IDX_W'(1'b1);
        end
      end
      S_RUN: begin
        if (flush_req_i) begin
          state_next_s = S_INIT;
        end else begin
          state_next_s = S_RUN;
        end
        index_next_s = {IDX_W{1'b0}};
      end
      default: begin
        state_next_s = S_INIT;
        index_next_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // Port arbitration: a queued update takes the port when Fetch is idle, the
  // queue is full, or the head has been denied long enough.
  always_comb begin
    in_run_s = (state_r == S_RUN);
    ready_s  = 1'b0;
    grant_s  = 1'b0;
    if (in_run_s && !flush_req_i) begin
      ready_s = !fifo_full_s;
      grant_s = !fifo_empty_s &&
                (!lookup_req_i || fifo_full_s || (wait_r >= WAIT_MAX));
    end else begin
      ready_s = 1'b0;
      grant_s = 1'b0;
    end
  end

  // Starvation counter: counts denied head cycles, saturating at the limit.
  always_comb begin
    wait_next_s = wait_r;
    if (flush_req_i || grant_s) begin
      wait_next_s = {WAIT_W{1'b0}};
    end else if (in_run_s && !fifo_empty_s) begin
      wait_next_s = (wait_r >= WAIT_MAX) ? WAIT_MAX : wait_r + WAIT_W'(1'b1);
    end else begin
      wait_next_s = wait_r;
    end
  end

  assign push_s           = upd_valid_i && ready_s;
  assign upd_ready_o      = ready_s;
  assign pred_upd_valid_o = grant_s;
  assign pred_upd_o       = head_s;
  assign lookup_stall_o   = grant_s && lookup_req_i;
  assign init_valid_o     = init_active_r;
  assign pred_disable_o   = init_active_r;
  assign init_index_o     = index_r;

  // Control state registers; init_active_r mirrors S_INIT as a clean registered strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= S_INIT;
      index_r       <= {IDX_W{1'b0}};
      wait_r        <= {WAIT_W{1'b0}};
      init_active_r <= 1'b1;
    end else begin
      state_r       <= state_next_s;
      index_r       <= index_next_s;
      wait_r        <= wait_next_s;
      init_active_r <= (state_next_s == S_INIT);
    end
  end

endmodule
